// File: rtl/mp_add_sub.sv
// Multi-limb add/subtract unit: streams LS limb first, chains carry/borrow
// internally, and reports final carry/borrow plus an all-zero flag.
module mp_add_sub #(
  parameter int unsigned CP_D_WIDTH = 72,
  parameter int unsigned NUM_LIMBS  = 8,
  parameter int unsigned CNT_W      = $clog2(NUM_LIMBS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic                  carry_init,
  input  logic [CNT_W-1:0]      num_limbs,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CP_D_WIDTH-1:0] in_a,
  input  logic [CP_D_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CP_D_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  carry_out,
  output logic                  zero_out
);

  localparam int unsigned W  = CP_D_WIDTH;
  localparam int unsigned W1 = CP_D_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             add_q, add_d;
  logic             carry_q, carry_d;
  logic             zero_acc_q, zero_acc_d;
  logic [CNT_W-1:0] limb_cnt_q, limb_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_out_q, zero_out_d;

  logic             in_fire;
  logic             out_fire;
  logic             is_last;
  logic [W:0]       sum;
  logic [CNT_W-1:0] len_eff;

  // Single output register: accept a new limb whenever the slot is free or draining.
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign busy      = (state_q != IDLE);
  assign is_last   = (limb_cnt_q == len_q - CNT_W'(1));
  assign len_eff   = ((num_limbs == '0) || (32'(num_limbs) > NUM_LIMBS)) ?
                     CNT_W'(NUM_LIMBS) : num_limbs;
  // Bit W is carry for add and borrow for subtract (two's-complement wrap).
  assign sum       = add_q ? ({1'b0, in_a} + {1'b0, in_b} + W1'(carry_q))
                           : ({1'b0, in_a} - {1'b0, in_b} - W1'(carry_q));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign carry_out = carry_out_q;
  assign zero_out  = zero_out_q;

  always_comb begin
    state_d     = state_q;
    add_d       = add_q;
    carry_d     = carry_q;
    zero_acc_d  = zero_acc_q;
    limb_cnt_d  = limb_cnt_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    carry_out_d = carry_out_q;
    zero_out_d  = zero_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          add_d      = op[0];
          carry_d    = op[1] & carry_init;
          len_d      = len_eff;
          limb_cnt_d = '0;
          zero_acc_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          out_data_d  = sum[W-1:0];
          carry_d     = sum[W];
          zero_acc_d  = zero_acc_q & (sum[W-1:0] == '0);
          out_valid_d = 1'b1;
          out_last_d  = is_last;
          limb_cnt_d  = limb_cnt_q + CNT_W'(1);
          if (is_last) begin
            state_d = DRAIN;
          end
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          carry_out_d = carry_q;
          zero_out_d  = zero_acc_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      add_q       <= 1'b0;
      carry_q     <= 1'b0;
      zero_acc_q  <= 1'b0;
      limb_cnt_q  <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      zero_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      add_q       <= add_d;
      carry_q     <= carry_d;
      zero_acc_q  <= zero_acc_d;
      limb_cnt_q  <= limb_cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
      zero_out_q  <= zero_out_d;
    end
  end

endmodule

// File: doc/mp_add_sub.md
# mp_add_sub

Multi-limb add/subtract unit for the CP cluster datapath. It streams operands of up to NUM_LIMBS limbs of CP_D_WIDTH bits, least-significant limb first, and propagates carry or borrow between limbs internally. It returns one result limb per accepted input limb, plus final carry/borrow and an all-zero flag. It replaces the single-word adder with its externally sequenced carry register, and adds valid/ready flow control, a per-operation limb count and compare-style zero detection.

## Interface

- CP_D_WIDTH, 72, limb width in bits
- NUM_LIMBS, 8, maximum limbs per operation (≥2)
- CNT_W, $clog2(NUM_LIMBS+1), limb counter width

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request, sampled only in IDLE
- op  in  2  op[0]: 1 = add, 0 = subtract; op[1]: 1 = use carry_init as limb-0 carry-in, 0 = carry-in 0
- carry_init  in  1  initial carry (add) or borrow (subtract)
- num_limbs  in  CNT_W  limbs in this operation; 0 or >NUM_LIMBS means NUM_LIMBS
- in_valid / in_ready  in / out  1  operand limb handshake
- in_a, in_b  in  CP_D_WIDTH  operand limbs
- out_valid / out_ready  out / in  1  result limb handshake
- out_data  out  CP_D_WIDTH  result limb
- out_last  out  1  marks the final result limb
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at completion
- carry_out  out  1  final carry (add) or borrow (subtract), valid while done=1 and held until next start
- zero_out  out  1  1 if all result limbs were zero; same validity as carry_out

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. On start=1, latch op, carry_init and effective num_limbs; set carry register to op[1] ? carry_init : 0; set limb_cnt=0 and zero_acc=1; go to RUN. While busy=1, start is ignored.
- RUN: in_ready = !out_valid || out_ready (single output register).
- In fire (in_valid && in_ready): compute a (W+1)-bit result. For add: in_a + in_b + c. For subtract: in_a − in_b − c.
  - out_data ← result[W-1:0].
  - carry register ← result[W]. For subtract this bit is the borrow.
  - zero_acc ← zero_acc & (result[W-1:0]==0); out_valid ← 1; limb_cnt ← limb_cnt+1.
  - out_last ← (limb_cnt == num_limbs−1).
  - If that limb is the last, go to DRAIN.
- Out fire without an in fire clears out_valid.
- DRAIN: in_ready=0. When the out_last limb fires: done ← 1, carry_out ← carry register, zero_out ← zero_acc, go to IDLE.
- done lasts exactly one cycle. start is accepted in the same cycle done is high, since the state is already IDLE.
- Width rules: all arithmetic is modulo 2^W per limb. Carry/borrow is exactly one bit and is never lost between limbs, including across backpressure stalls.
- Reset (any state, including mid-stream): state=IDLE, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0, done=0, carry_out=0, zero_out=0, carry register=0, limb_cnt=0. Partial results are discarded.

## Timing

- Result latency: 1 cycle from in fire to out_valid.
- Throughput: 1 limb/cycle while out_ready=1. Total time from start is num_limbs+2 cycles minimum: start → RUN (1), limbs, then done registered one cycle after the last out fire.
- Backpressure: when out_ready=0, out_data, out_last and out_valid are held stable and in_ready=0 the same cycle. No combinational path from in_valid to in_ready.
- Simultaneous out fire and in fire in RUN: the output register reloads with the new limb with no bubble.
- in_valid in IDLE or DRAIN is ignored, with no data consumed.

## Test plan

(CP_D_WIDTH=8, NUM_LIMBS=4 for all.)
- Add, 2 limbs, op=01: A=0x01FF, B=0x0001 (limbs FF/01, 01/00) → out 00 then 02, out_last on second, done with carry_out=0, zero_out=0.
- Subtract, 3 limbs, op=00: A=0x000000, B=0x000001 → out FF, FF, FF; carry_out=1 (borrow), zero_out=0; compare A==A gives 00,00,00 with zero_out=1, carry_out=0.
- Initial carry, op=11, carry_init=1, num_limbs=1: A=FF, B=00 → out 00, carry_out=1, zero_out=1. Same with op=01 → out FF, carry_out=0.
- Backpressure: 4-limb add with out_ready low for 3 cycles after limb 1 → in_ready low those cycles, out_data held, all 4 limbs correct, carry chained correctly across the stall.
- Reset after 2 of 4 limbs → next cycle all outputs at reset values and busy=0. A new 1-limb op then completes correctly, with no stale carry.
- start pulsed while busy is ignored. num_limbs=0 runs 4 limbs. Back-to-back start in the done cycle is accepted and busy is reasserted the next cycle.
